risc32_regfile_hilo: RTL
========================

// Module: risc32_regfile_hilo
// PURPOSE
// - Architectural state sink for the write-back stage: 32-entry GPR file plus HI/LO pair.
// - Consumes WB outputs (dest addr, write enable, data, hi, lo, hilo enable) and commits them on the clock edge.
// - Serves decode with two GPR read ports and execute with one HI/LO read port.
// - Write-to-read bypass means a read in the same cycle as a write returns the new value.
// PARAMETERS
// - DATA_WIDTH  32  width of each GPR, HI and LO
// - ADDR_WIDTH  5   GPR address width
// - NUM_REGS    32  GPR count; must equal 2**ADDR_WIDTH
// PORTS
// - clk     in   1           system clock; all state updates on rising edge
// - rst     in   1           synchronous, active-high reset
// - we      in   1           GPR write enable (from WB wreg)
// - waddr   in   ADDR_WIDTH  GPR write address (from WB wd)
// - wdata   in   DATA_WIDTH  GPR write data (from WB wdata)
// - re1     in   1           read-port-1 enable
// - raddr1  in   ADDR_WIDTH  read-port-1 address
// - rdata1  out  DATA_WIDTH  read-port-1 data (combinational)
// - re2     in   1           read-port-2 enable
// - raddr2  in   ADDR_WIDTH  read-port-2 address
// - rdata2  out  DATA_WIDTH  read-port-2 data (combinational)
// - whilo   in   1           HI/LO write enable (from WB whilo)
// - hi_i    in   DATA_WIDTH  HI write data
// - lo_i    in   DATA_WIDTH  LO write data
// - hi_o    out  DATA_WIDTH  current HI (bypassed)
// - lo_o    out  DATA_WIDTH  current LO (bypassed)
// BEHAVIOUR
// - Reset: clk edge with rst=1 clears all GPRs, HI and LO to 0; any write on that edge is dropped.
// - While rst=1: rdata1, rdata2, hi_o, lo_o are driven 0 combinationally.
// - GPR write: on clk edge with rst=0, we=1, waddr!=0 -> regs[waddr] <= wdata; latency 1 edge.
// - r0: writes to waddr=0 ignored; reads of raddr=0 always return 0, even with a bypass match.
// - Read port n (n=1,2), priority order:
//   1. rst=1 -> 0
//   2. ren=0 -> 0
//   3. raddrn=0 -> 0
//   4. we=1 and waddr==raddrn -> wdata (same-cycle bypass)
//   5. else regs[raddrn]
// - Both ports may read the same address and the written address simultaneously; both get identical data.
// - HI/LO write: on clk edge with rst=0, whilo=1 -> HI<=hi_i and LO<=lo_i together; never one alone.
// - HI/LO read: rst=1 -> 0; whilo=1 -> hi_i/lo_i (bypass); else stored HI/LO.
// - GPR and HI/LO paths are independent; we and whilo may both be 1 in one cycle, and both commit.
// - No X propagation: outputs are always fully defined once rst has been asserted for one edge.
// - Reset mid-operation: pending write dropped, state zero, reads return 0 until rst deasserts.
// - Timing: read ports are combinational (address -> data in same cycle); writes are edge-registered only.
// TESTING
// - Reset: rst=1 one edge, then read all 32 addrs with re1=re2=1 -> all 0; hi_o=lo_o=0.
// - Write/read: we=1 waddr=5 wdata=32'hDEADBEEF, edge; then raddr1=5 re1=1 -> rdata1=32'hDEADBEEF.
// - Bypass: same cycle we=1 waddr=7 wdata=32'h12345678, raddr1=raddr2=7 -> both rdata=32'h12345678 before edge.
// - r0 + disable: we=1 waddr=0 wdata=32'hFFFFFFFF, edge; raddr1=0 -> 0; re2=0 raddr2=5 -> 0.
// - HI/LO: whilo=1 hi_i=32'hA5A5A5A5 lo_i=32'h5A5A5A5A -> hi_o/lo_o equal inputs the same cycle and hold them after whilo=0.
// - Reset mid-write: rst=1 with we=1 waddr=9 wdata=32'h1 and whilo=1 on the same edge -> regs[9]=0, HI=LO=0 after rst drops.

Source files
------------

// File: rtl/risc32_regfile_hilo_if.sv
// rtl/risc32_regfile_hilo_if.sv - write-back / read port bundle for the GPR file and HI/LO pair
interface risc32_regfile_hilo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // GPR write port (from write-back)
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  // GPR read ports (to decode)
  logic                  re1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  re2;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata2;

  // HI/LO write and read (from write-back, to execute)
  logic                  whilo;
  logic [DATA_WIDTH-1:0] hi_i;
  logic [DATA_WIDTH-1:0] lo_i;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2,
    output whilo, hi_i, lo_i,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2,
    input  whilo, hi_i, lo_i,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/risc32_regfile_hilo.sv
// rtl/risc32_regfile_hilo.sv - 32-entry GPR file plus HI/LO pair with same-cycle write bypass
module risc32_regfile_hilo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input logic                  clk,
  input logic                  rst,
  risc32_regfile_hilo_if.slave rf
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] hi_d;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [DATA_WIDTH-1:0] lo_d;

  // One read port: reset and disable force zero, r0 is hardwired zero even
  // against a matching write, otherwise an in-flight write wins over storage.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  rst_i,
    input logic                  ren,
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic                  we_i,
    input logic [ADDR_WIDTH-1:0] waddr_i,
    input logic [DATA_WIDTH-1:0] wdata_i,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    if (rst_i || !ren || (raddr == '0)) begin
      r = '0;
    end else if (we_i && (waddr_i == raddr)) begin
      r = wdata_i;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Next-state of GPRs and HI/LO: commit the write-back results, never r0
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    hi_d = hi_q;
    lo_d = lo_q;
    if (rf.we && (rf.waddr != '0)) begin
      regs_d[rf.waddr] = rf.wdata;
    end
    // HI and LO always move as a pair
    if (rf.whilo) begin
      hi_d = rf.hi_i;
      lo_d = rf.lo_i;
    end
  end

  // State registers; reset clears everything and drops any write on that edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Combinational read ports with write-to-read bypass
  always_comb begin
    rf.rdata1 = read_port(rst, rf.re1, rf.raddr1, rf.we, rf.waddr, rf.wdata,
                          regs_q[rf.raddr1]);
    rf.rdata2 = read_port(rst, rf.re2, rf.raddr2, rf.we, rf.waddr, rf.wdata,
                          regs_q[rf.raddr2]);
  end

  // HI/LO read: zero in reset, incoming pair when written this cycle
  always_comb begin
    rf.hi_o = '0;
    rf.lo_o = '0;
    if (rst) begin
      rf.hi_o = '0;
      rf.lo_o = '0;
    end else if (rf.whilo) begin
      rf.hi_o = rf.hi_i;
      rf.lo_o = rf.lo_i;
    end else begin
      rf.hi_o = hi_q;
      rf.lo_o = lo_q;
    end
  end

endmodule
